// File: rtl/wb_arbiter_rr_if.sv
// Wishbone arbiter bundle: per-master request lines plus the shared slave-path signals.
// The arbiter takes the slave modport; the requesting masters and the slave path drive through master.
interface wb_arbiter_rr_if #(
   parameter int NUMM = 3
) ();
   localparam int IW = $clog2(NUMM);

   logic [NUMM-1:0] m_cyc;
   logic [NUMM-1:0] m_stb;
   logic            s_ack;
   logic            s_err;
   logic            s_stall;
   logic            s_cyc;
   logic            s_stb;
   logic [NUMM-1:0] grant;
   logic [IW-1:0]   grant_idx;
   logic            m_stall;
   logic            m_err_inj;
   logic            timeout_evt;

   modport slave (
      input  m_cyc, m_stb, s_ack, s_err, s_stall,
      output s_cyc, s_stb, grant, grant_idx, m_stall, m_err_inj, timeout_evt
   );

   modport master (
      output m_cyc, m_stb, s_ack, s_err, s_stall,
      input  s_cyc, s_stb, grant, grant_idx, m_stall, m_err_inj, timeout_evt
   );
endinterface

// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone arbiter: one master owns the slave path per cyc tenure, with an
// outstanding-request limit and a watchdog that aborts a silent slave via an injected error.
module wb_arbiter_rr #(
   parameter int NUMM    = 3,
   parameter int MAXOUT  = 4,
   parameter int TIMEOUT = 255
) (
   input logic            clk,
   input logic            rst_n,
   wb_arbiter_rr_if.slave bus
);
   localparam int IW = $clog2(NUMM);
   localparam int OW = $clog2(MAXOUT + 1);

   typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_e;

   state_e          state_q, state_d;
   logic [NUMM-1:0] grant_q, grant_d;
   logic [IW-1:0]   gidx_q, gidx_d;
   logic [IW-1:0]   last_q, last_d;
   logic [OW-1:0]   out_q, out_d;
   logic [15:0]     wdt_q, wdt_d;
   logic            err_inj_q, err_inj_d;

   logic            arb_hit;
   logic [IW-1:0]   arb_idx;
   int              cand;
   logic            own_cyc;
   logic            resp;
   logic            accept;
   logic            out_full;
   logic            expire;
   logic            s_stb_w;
   logic            m_stall_w;

   // Search starts just after the previous winner, so every requester is reached within NUMM grants.
   always_comb begin
      arb_hit = 1'b0;
      arb_idx = '0;
      cand    = 0;
      for (int k = 1; k <= NUMM; k++) begin
         cand = int'(last_q) + k;
         if (cand >= NUMM) cand = cand - NUMM;
         if (!arb_hit && bus.m_cyc[cand[IW-1:0]]) begin
            arb_hit = 1'b1;
            arb_idx = cand[IW-1:0];
         end
      end
   end

   assign own_cyc   = bus.m_cyc[gidx_q];
   assign resp      = bus.s_ack | bus.s_err;
   assign out_full  = (out_q == OW'(MAXOUT));
   assign s_stb_w   = (state_q == BUSY) & bus.m_stb[gidx_q];
   assign m_stall_w = (state_q == ABORT) | ((state_q == BUSY) & (bus.s_stall | out_full));
   assign accept    = s_stb_w & ~m_stall_w;
   // A response in the expiry cycle counts as progress and suppresses the abort.
   assign expire    = (out_q != '0) & ~resp & (wdt_q == 16'(TIMEOUT - 1));

   assign bus.s_cyc       = (state_q == BUSY) & own_cyc;
   assign bus.s_stb       = s_stb_w;
   assign bus.m_stall     = m_stall_w;
   assign bus.grant       = grant_q;
   assign bus.grant_idx   = gidx_q;
   assign bus.m_err_inj   = err_inj_q;
   assign bus.timeout_evt = err_inj_q;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      gidx_d    = gidx_q;
      last_d    = last_q;
      out_d     = out_q;
      wdt_d     = wdt_q;
      err_inj_d = 1'b0;
      case (state_q)
         IDLE: begin
            out_d = '0;
            wdt_d = '0;
            if (arb_hit) begin
               state_d = BUSY;
               grant_d = NUMM'(1) << arb_idx;
               gidx_d  = arb_idx;
               last_d  = arb_idx;
            end
         end
         BUSY, ABORT: begin
            if (!own_cyc) begin
               // Owner ended its tenure: drop in-flight responses and hand off directly.
               out_d = '0;
               wdt_d = '0;
               if (arb_hit) begin
                  state_d = BUSY;
                  grant_d = NUMM'(1) << arb_idx;
                  gidx_d  = arb_idx;
                  last_d  = arb_idx;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
               end
            end else if (state_q == ABORT) begin
               out_d = '0;
               wdt_d = '0;
            end else if (expire) begin
               state_d   = ABORT;
               err_inj_d = 1'b1;
               out_d     = '0;
               wdt_d     = '0;
            end else begin
               wdt_d = ((out_q == '0) || resp) ? 16'd0 : wdt_q + 16'd1;
               case ({accept, resp && (out_q != '0)})
                  2'b10:   out_d = out_q + OW'(1);
                  2'b01:   out_d = out_q - OW'(1);
                  default: out_d = out_q;
               endcase
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         gidx_q    <= '0;
         last_q    <= IW'(NUMM - 1);
         out_q     <= '0;
         wdt_q     <= '0;
         err_inj_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         gidx_q    <= gidx_d;
         last_q    <= last_d;
         out_q     <= out_d;
         wdt_q     <= wdt_d;
         err_inj_q <= err_inj_d;
      end
   end
endmodule

// File: tb/tb_wb_arbiter_rr.sv
module tb_wb_arbiter_rr;
   localparam int N  = 3;
   localparam int MO = 4;
   localparam int TO = 8;
   localparam int IW = $clog2(N);

   typedef struct packed {
      logic [N-1:0]  grant;
      logic [IW-1:0] gidx;
      logic          s_cyc;
      logic          s_stb;
      logic          m_stall;
      logic          err_inj;
      logic          tevt;
   } out_t;

   logic clk = 1'b0;
   logic rst_n;

   wb_arbiter_rr_if #(.NUMM(N)) bus ();

   wb_arbiter_rr #(.NUMM(N), .MAXOUT(MO), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   out_t exp_q[$];
   int   tag_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   phase    = 0;
   int   ncyc     = 0;

   int owner, last, gidx, pending, silent;
   bit aborted, pulse;

   function automatic void model_reset();
      owner = -1; last = N - 1; gidx = 0;
      pending = 0; silent = 0; aborted = 0; pulse = 0;
   endfunction

   function automatic int pick(input logic [N-1:0] c);
      for (int k = 1; k <= N; k++)
         if (c[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   function automatic out_t exp_out(input logic [N-1:0] cyc, stb, input logic stall);
      out_t e;
      e = '0;
      e.gidx = IW'(gidx);
      e.err_inj = pulse;
      e.tevt = pulse;
      if (owner >= 0) begin
         e.grant[owner] = 1'b1;
         if (aborted) e.m_stall = 1'b1;
         else begin
            e.s_cyc   = cyc[owner];
            e.s_stb   = stb[owner];
            e.m_stall = stall || (pending == MO);
         end
      end
      return e;
   endfunction

   task automatic chk(input bit ok, input string what);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s phase=%0d cyc=%0d grant=%b idx=%0d scyc=%b sstb=%b stall=%b err=%b evt=%b",
                  what, phase, ncyc, bus.grant, bus.grant_idx, bus.s_cyc, bus.s_stb,
                  bus.m_stall, bus.m_err_inj, bus.timeout_evt);
      end
   endtask

   task automatic step(input logic [N-1:0] cyc, stb, input logic ack, err, stall);
      out_t e;
      bit resp, acc, tmo, dec;
      int nxt;
      rst_n = 1'b1;
      bus.m_cyc = cyc; bus.m_stb = stb;
      bus.s_ack = ack; bus.s_err = err; bus.s_stall = stall;
      e = exp_out(cyc, stb, stall);
      exp_q.push_back(e);
      tag_q.push_back(phase);
      resp  = ack | err;
      pulse = 0;
      if (owner < 0) begin
         if (cyc != '0) begin
            nxt = pick(cyc); owner = nxt; last = nxt; gidx = nxt;
         end
      end else if (!cyc[owner]) begin
         pending = 0; silent = 0; aborted = 0;
         if (cyc != '0) begin
            nxt = pick(cyc); owner = nxt; last = nxt; gidx = nxt;
         end else owner = -1;
      end else if (aborted) begin
         pending = 0; silent = 0;
      end else begin
         acc = e.s_stb && !e.m_stall;
         dec = resp && (pending > 0);
         tmo = (pending > 0) && !resp && (silent == TO - 1);
         silent  = (pending == 0 || resp) ? 0 : silent + 1;
         pending = pending + int'(acc) - int'(dec);
         if (tmo) begin
            aborted = 1; pulse = 1; pending = 0; silent = 0;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic rst_step();
      rst_n = 1'b0;
      bus.m_cyc = '0; bus.m_stb = '0;
      bus.s_ack = 1'b0; bus.s_err = 1'b0; bus.s_stall = 1'b0;
      model_reset();
      exp_q.push_back(exp_out('0, '0, 1'b0));
      tag_q.push_back(phase);
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      out_t a, e;
      int   t;
      ncyc++;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         a.grant = bus.grant; a.gidx = bus.grant_idx;
         a.s_cyc = bus.s_cyc; a.s_stb = bus.s_stb; a.m_stall = bus.m_stall;
         a.err_inj = bus.m_err_inj; a.tevt = bus.timeout_evt;
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL outputs phase=%0d cyc=%0d got grant=%b idx=%0d scyc=%b sstb=%b stall=%b err=%b evt=%b want grant=%b idx=%0d scyc=%b sstb=%b stall=%b err=%b evt=%b",
                     t, ncyc, a.grant, a.gidx, a.s_cyc, a.s_stb, a.m_stall, a.err_inj, a.tevt,
                     e.grant, e.gidx, e.s_cyc, e.s_stb, e.m_stall, e.err_inj, e.tevt);
         end
      end
   end

   initial begin
      logic [N-1:0] rc;
      int ackp;
      int o;
      rst_n = 1'b0;
      bus.m_cyc = '0; bus.m_stb = '0;
      bus.s_ack = 1'b0; bus.s_err = 1'b0; bus.s_stall = 1'b0;
      model_reset();
      @(posedge clk); #1;

      phase = 0;
      rst_step(); rst_step();
      chk(bus.grant === '0 && bus.grant_idx === '0 && bus.s_cyc === 1'b0 &&
          bus.s_stb === 1'b0 && bus.m_stall === 1'b0 && bus.m_err_inj === 1'b0 &&
          bus.timeout_evt === 1'b0, "reset-state");

      phase = 1;
      step(3'b010, 3'b000, 0, 0, 0);
      repeat (3) step(3'b010, 3'b010, 0, 0, 0);
      repeat (3) step(3'b010, 3'b000, 1, 0, 0);
      repeat (2) step(3'b000, 3'b000, 0, 0, 0);

      phase = 2;
      rst_step();
      step(3'b111, 3'b000, 0, 0, 0);
      for (int t = 0; t < 6; t++) begin
         o = owner;
         step(3'b111, 3'(1 << o), 0, 0, 0);
         step(3'b111, 3'b000, 1, 0, 0);
         step(3'b111 & ~3'(1 << o), 3'b000, 0, 0, 0);
      end
      repeat (2) step(3'b000, 3'b000, 0, 0, 0);

      phase = 3;
      step(3'b100, 3'b000, 0, 0, 0);
      repeat (5) step(3'b100, 3'b100, 0, 0, 0);
      step(3'b100, 3'b100, 1, 0, 0);
      step(3'b100, 3'b000, 0, 0, 0);
      step(3'b100, 3'b000, 1, 0, 0);
      step(3'b100, 3'b000, 0, 1, 0);
      step(3'b000, 3'b000, 1, 0, 0);
      step(3'b000, 3'b000, 0, 0, 0);

      phase = 4;
      step(3'b001, 3'b000, 0, 0, 0);
      step(3'b001, 3'b001, 0, 0, 0);
      for (int k = 1; k <= 12; k++) begin
         chk(bus.m_err_inj === (k == TO + 1) && bus.timeout_evt === (k == TO + 1) &&
             bus.grant === 3'b001 && (k < TO + 1 || bus.s_cyc === 1'b0), "expired-wait");
         step(3'b001, 3'b000, 0, 0, 0);
      end
      step(3'b000, 3'b000, 0, 0, 0);
      step(3'b000, 3'b000, 0, 0, 0);

      phase = 5;
      step(3'b010, 3'b000, 0, 0, 0);
      step(3'b010, 3'b010, 0, 0, 0);
      repeat (TO - 1) step(3'b010, 3'b000, 0, 0, 0);
      step(3'b010, 3'b000, 1, 0, 0);
      repeat (4) step(3'b010, 3'b000, 0, 0, 0);
      step(3'b010, 3'b000, 1, 0, 0);
      step(3'b000, 3'b000, 0, 0, 0);

      phase = 6;
      step(3'b110, 3'b000, 0, 0, 0);
      step(3'b110, 3'b110, 0, 0, 0);
      rst_step();
      repeat (3) step(3'b111, 3'b000, 0, 0, 0);
      step(3'b000, 3'b000, 0, 0, 0);

      phase = 7;
      rc = '0;
      for (int seg = 0; seg < 12; seg++) begin
         ackp = (seg % 3 == 0) ? 0 : (seg % 3 == 1) ? 15 : 60;
         for (int n = 0; n < 150; n++) begin
            logic a, er;
            for (int i = 0; i < N; i++) begin
               if (rc[i] && $urandom_range(0, 99) < 6) rc[i] = 1'b0;
               else if (!rc[i] && $urandom_range(0, 99) < 25) rc[i] = 1'b1;
            end
            a  = ($urandom_range(0, 99) < ackp);
            er = !a && ($urandom_range(0, 99) < 3);
            step(rc, 3'($urandom), a, er, $urandom_range(0, 99) < 20);
         end
         if (seg == 5) rst_step();
      end
      step(3'b000, 3'b000, 0, 0, 0);

      @(negedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
